// File: rtl/srq_scheduler.sv
// ---------------------------------------------------------------------------
// srq_scheduler
//   Round-robin service-request scheduler for the embedded CPU. Latches
//   one-cycle SRQ pulses from CHANS demodulator channels plus the host, and
//   grants one service at a time. The CPU reads gnt_id and answers with done.
//   The host request has absolute priority. The channels are served
//   round-robin from a pointer that moves past each channel it serves.
//   Overruns (a request arriving while the same one is still pending) and
//   stalled grants (no done within 2**TMO_W-1 cycles) are recorded as
//   sticky status.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   srq_in     request pulses; [CHANS] = host, [CHANS-1:0] = channels
//   srq_mask   channel enables (the host is never masked)
//   hold       blocks new grants; an outstanding grant is unaffected
//   done       CPU finished servicing gnt_id
//   clr        clears overrun, drop_cnt and tmo_flag
//   gnt_valid  a grant is outstanding
//   gnt_id     granted index (CHANS = host); meaningful while gnt_valid
//   pending    latched unserviced requests
//   overrun    sticky per-channel overrun flags
//   drop_cnt   saturating count of overrun events
//   tmo_flag   sticky: a grant timed out without done
// ---------------------------------------------------------------------------
module srq_scheduler #(
  parameter int CHANS = 12,
  parameter int TMO_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CHANS:0]   srq_in,
  input  logic [CHANS-1:0] srq_mask,
  input  logic             hold,
  input  logic             done,
  input  logic             clr,
  output logic             gnt_valid,
  output logic [3:0]       gnt_id,
  output logic [CHANS:0]   pending,
  output logic [CHANS-1:0] overrun,
  output logic [7:0]       drop_cnt,
  output logic             tmo_flag
);

  generate
    if (CHANS < 1 || CHANS > 15 || TMO_W < 2) begin : g_param_check
      $error("srq_scheduler: CHANS must be 1..15 and TMO_W must be >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0]       HOST_ID  = 4'(CHANS);
  localparam logic [3:0]       LAST_CH  = 4'(CHANS - 1);
  localparam logic [CHANS:0]   ONE_HOT0 = {{CHANS{1'b0}}, 1'b1};
  // The counter starts at 0 in the first GRANT cycle, so this value marks
  // the (2**TMO_W-1)-th cycle in GRANT.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q;
  logic [3:0]       ptr_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             gnt_valid_q;
  logic [3:0]       gnt_id_q;
  logic [CHANS:0]   pending_q, pending_d;
  logic [CHANS-1:0] overrun_q, overrun_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             tmo_flag_q;

  logic [CHANS:0]   mask_full;
  logic [CHANS:0]   eligible;
  logic [CHANS:0]   clear_vec;
  logic [CHANS:0]   ovr_ev;
  logic [3:0]       winner;
  logic             found;
  logic             grant_go;
  logic [4:0]       sum;
  logic [7:0]       drop_base;
  logic [3:0]       ptr_next;
  logic             timeout;

  always_comb begin
    mask_full = {1'b1, srq_mask};
    eligible  = pending_q & mask_full;
    winner    = '0;
    found     = 1'b0;
    sum       = '0;
    if (eligible[CHANS]) begin
      winner = HOST_ID;
      found  = 1'b1;
    end else begin
      // Scan upward from ptr, wrapping at CHANS-1; the first hit wins.
      for (int unsigned k = 0; k < CHANS; k++) begin
        sum = {1'b0, ptr_q} + 5'(k);
        if (sum >= 5'(CHANS)) begin
          sum = sum - 5'(CHANS);
        end
        if (!found && eligible[sum[3:0]]) begin
          winner = sum[3:0];
          found  = 1'b1;
        end
      end
    end

    grant_go  = (state_q == IDLE) && !hold && found;
    clear_vec = grant_go ? (ONE_HOT0 << winner) : '0;

    // A request landing on the bit being granted re-pends it instead of
    // counting as an overrun.
    ovr_ev    = srq_in & pending_q & mask_full & ~clear_vec;
    pending_d = mask_full & ((pending_q & ~clear_vec) | srq_in);

    // clr and a same-cycle overrun: the new event survives the clear.
    overrun_d  = (clr ? '0 : overrun_q) | ovr_ev[CHANS-1:0];
    drop_base  = clr ? '0 : drop_cnt_q;
    drop_cnt_d = (|ovr_ev && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;

    ptr_next = (gnt_id_q == LAST_CH) ? '0 : gnt_id_q + 4'd1;
    timeout  = (tmo_cnt_q == TMO_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tmo_cnt_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      drop_cnt_q  <= '0;
      tmo_flag_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
      if (clr) begin
        tmo_flag_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (grant_go) begin
            gnt_id_q    <= winner;
            gnt_valid_q <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          if (done || timeout) begin
            gnt_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (gnt_id_q != HOST_ID) begin
              ptr_q <= ptr_next;
            end
            // done wins over a coincident timeout.
            if (!done) begin
              tmo_flag_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign drop_cnt  = drop_cnt_q;
  assign tmo_flag  = tmo_flag_q;

endmodule

// File: tb/tb_srq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_srq_scheduler
//   Directed bench for srq_scheduler (CHANS=12, TMO_W=4). A behavioural
//   model tracks pending requests, the round-robin pointer and the grant
//   lifetime in plain integers. Every falling edge compares the DUT against
//   it. The directed scenarios also pin key values to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_srq_scheduler;

  localparam int CH      = 12;
  localparam int TMO_CYC = 15;   // 2**4 - 1 cycles in GRANT

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH:0]   srq_in = '0;
  logic [CH-1:0] srq_mask = '1;
  logic          hold = 1'b0;
  logic          done = 1'b0;
  logic          clr = 1'b0;
  logic          gnt_valid;
  logic [3:0]    gnt_id;
  logic [CH:0]   pending;
  logic [CH-1:0] overrun;
  logic [7:0]    drop_cnt;
  logic          tmo_flag;

  always #5 clk = ~clk;

  srq_scheduler #(.CHANS(CH), .TMO_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .srq_in   (srq_in),
    .srq_mask (srq_mask),
    .hold     (hold),
    .done     (done),
    .clr      (clr),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .pending  (pending),
    .overrun  (overrun),
    .drop_cnt (drop_cnt),
    .tmo_flag (tmo_flag)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend [0:CH];
  bit m_ovr  [0:CH-1];
  int m_drop, m_id, m_ptr, m_gcyc;
  bit m_tmo, m_valid;
  int mw_win, mw_nev;
  bit mw_np [0:CH];

  function automatic int pick();
    if (m_pend[CH]) return CH;
    for (int k = 0; k < CH; k++) begin
      int c = (m_ptr + k) % CH;
      if (m_pend[c] && srq_mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    foreach (m_ovr[i]) m_ovr[i] = 1'b0;
    m_drop = 0; m_id = 0; m_ptr = 0; m_gcyc = 0; m_tmo = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_end_grant(input bit timed_out);
    m_valid = 1'b0;
    if (m_id < CH) m_ptr = (m_id + 1) % CH;
    if (timed_out) m_tmo = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        mw_win = (!m_valid && !hold) ? pick() : -1;
        mw_nev = 0;
        if (clr) begin
          foreach (m_ovr[i]) m_ovr[i] = 1'b0;
          m_drop = 0;
          m_tmo  = 1'b0;
        end
        for (int i = 0; i <= CH; i++) begin
          if (i < CH && !srq_mask[i]) begin
            mw_np[i] = 1'b0;
          end else if (srq_in[i]) begin
            if (m_pend[i] && i != mw_win) begin
              mw_nev++;
              if (i < CH) m_ovr[i] = 1'b1;
            end
            mw_np[i] = 1'b1;
          end else begin
            mw_np[i] = m_pend[i] && (i != mw_win);
          end
        end
        if (mw_nev > 0 && m_drop < 255) m_drop++;
        if (m_valid) begin
          if (done) model_end_grant(1'b0);
          else if (m_gcyc == TMO_CYC) model_end_grant(1'b1);
          else m_gcyc++;
        end else if (mw_win >= 0) begin
          m_valid = 1'b1;
          m_id    = mw_win;
          m_gcyc  = 1;
        end
        m_pend = mw_np;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  int unsigned ep, eo;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        ep = 0;
        eo = 0;
        for (int i = 0; i <= CH; i++) if (m_pend[i]) ep |= (32'd1 << i);
        for (int i = 0; i < CH; i++) if (m_ovr[i]) eo |= (32'd1 << i);
        check("model.gnt_valid", gnt_valid, m_valid);
        if (m_valid) check("model.gnt_id", gnt_id, m_id);
        check("model.pending", pending, ep);
        check("model.overrun", overrun, eo);
        check("model.drop_cnt", drop_cnt, m_drop);
        check("model.tmo_flag", tmo_flag, m_tmo);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      srq_in = '0;
      done   = 1'b0;
      clr    = 1'b0;
    end
  endtask

  task automatic pulse(input int idx);
    srq_in[idx] = 1'b1;
  endtask

  task automatic wait_grant(input int exp, input string nm);
    int n = 0;
    while (!gnt_valid && n < 40) begin
      cyc(1);
      n++;
    end
    check({nm, ".valid"}, gnt_valid, 1);
    check({nm, ".id"}, gnt_id, exp);
  endtask

  task automatic finish_grant();
    cyc(2);
    done = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    #1 rst = 1'b0;
    cyc(2);
    check("reset.gnt_valid", gnt_valid, 0);
    check("reset.pending", pending, 0);
    check("reset.overrun", overrun, 0);
    check("reset.drop_cnt", drop_cnt, 0);
    check("reset.tmo_flag", tmo_flag, 0);
    cmp_en = 1'b1;
    rst = 1'b1;

    // 1: async reset mid-GRANT, pointer back to 0
    pulse(5); cyc(1); wait_grant(5, "t1.g5"); finish_grant();      // ptr -> 6
    pulse(8); cyc(1); wait_grant(8, "t1.g8");
    pulse(2); cyc(1);
    check("t1.pend2", pending, 13'h0004);
    #2 rst = 1'b0;
    #1;
    check("t1.rst_valid", gnt_valid, 0);
    check("t1.rst_pend", pending, 0);
    @(negedge clk);
    rst = 1'b1;
    pulse(3); pulse(10); cyc(1);
    check("t1.gap", gnt_valid, 0);
    cyc(1);
    check("t1.g3_valid", gnt_valid, 1);
    check("t1.g3_id", gnt_id, 3);
    finish_grant();
    wait_grant(10, "t1.g10"); finish_grant();                        // ptr -> 11

    // 2: round-robin ordering and wrap
    pulse(1); pulse(5); pulse(9); cyc(1);
    wait_grant(1, "t2.a1"); finish_grant();
    wait_grant(5, "t2.a5"); finish_grant();
    wait_grant(9, "t2.a9"); finish_grant();                          // ptr -> 10
    pulse(1); pulse(5); cyc(1);
    wait_grant(1, "t2.b1"); finish_grant();
    wait_grant(5, "t2.b5"); finish_grant();                          // ptr -> 6

    // 3: host priority
    pulse(4); cyc(1); wait_grant(4, "t3.g4");
    pulse(12); pulse(2); cyc(1);
    check("t3.pend", pending, 13'h1004);
    cyc(1); done = 1'b1; cyc(1);
    wait_grant(12, "t3.host"); finish_grant();
    wait_grant(2, "t3.g2"); finish_grant();                          // ptr -> 3

    // 4: overrun under hold, re-pend in grant cycle, clr race
    hold = 1'b1; pulse(7); cyc(1); cyc(4); pulse(7); cyc(1);
    check("t4.ovr", overrun, 12'h080);
    check("t4.drop", drop_cnt, 1);
    check("t4.hold_valid", gnt_valid, 0);
    hold = 1'b0; pulse(7); cyc(1);
    check("t4.g7_id", gnt_id, 7);
    check("t4.repend", pending, 13'h0080);
    check("t4.drop_same", drop_cnt, 1);
    finish_grant();
    wait_grant(7, "t4.g7b"); finish_grant();
    check("t4.pend_empty", pending, 0);
    hold = 1'b1; pulse(8); cyc(1);
    pulse(8); clr = 1'b1; cyc(1);
    check("t4.clr_race_ovr", overrun, 12'h100);
    check("t4.clr_race_drop", drop_cnt, 1);
    clr = 1'b1; cyc(1);
    check("t4.clr_ovr", overrun, 0);
    check("t4.clr_drop", drop_cnt, 0);
    hold = 1'b0;
    wait_grant(8, "t4.g8"); finish_grant();                          // ptr -> 9

    // 5: timeout after 15 cycles; done on the 15th cycle wins
    pulse(0); cyc(1); wait_grant(0, "t5.a");
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!gnt_valid) break;
      n++;
    end
    check("t5.grant_cycles", n, TMO_CYC);
    check("t5.tmo_set", tmo_flag, 1);
    clr = 1'b1; cyc(1);
    check("t5.tmo_clr", tmo_flag, 0);
    pulse(0); cyc(1); wait_grant(0, "t5.b");
    cyc(14);
    check("t5.still_valid", gnt_valid, 1);
    done = 1'b1; cyc(1);
    check("t5.done_valid", gnt_valid, 0);
    check("t5.done_tmo", tmo_flag, 0);

    // 6: masking
    hold = 1'b1; pulse(6); cyc(1);
    check("t6.pend6", pending, 13'h0040);
    srq_mask[6] = 1'b0; hold = 1'b0; cyc(1);
    check("t6.masked_pend", pending, 0);
    check("t6.masked_valid", gnt_valid, 0);
    cyc(1);
    check("t6.no_grant", gnt_valid, 0);
    pulse(6); cyc(1);
    check("t6.ign_pend", pending, 0);
    check("t6.ign_ovr", overrun, 0);
    srq_mask[6] = 1'b1; cyc(1);
    pulse(6); cyc(1); wait_grant(6, "t6.g6");
    srq_mask[6] = 1'b0; cyc(3);
    check("t6.mid_valid", gnt_valid, 1);
    check("t6.mid_id", gnt_id, 6);
    done = 1'b1; cyc(1);
    check("t6.end_valid", gnt_valid, 0);
    srq_mask = '1; cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
